// File: rtl/cp_insert.sv
`default_nettype none
// ============================================================================
//  Module      : cp_insert
//  Description : Cyclic-prefix insertion for OFDM symbols. Whole symbols of
//                NFFT samples arrive from the IFFT over a Wishbone-style
//                write port and are collected in a ping-pong buffer. Each
//                stored symbol is replayed as its last NCP samples followed
//                by all NFFT samples.
//  Ports       : CLK_I                   clock, rising edge
//                RST_I                   asynchronous reset, active low
//                DAT_I[31:0]             input sample {I[15:0],Q[15:0]}
//                CYC_I/STB_I/WE_I/ACK_O  upstream write handshake
//                DAT_O[31:0]             registered output sample
//                CYC_O/STB_O/WE_O/ACK_I  downstream write handshake
//  Revision    : 1.0  initial release
// ============================================================================
module cp_insert #(
    parameter int NFFT = 64,
    parameter int NCP  = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    localparam int c_AW = $clog2(NFFT);
    // rcnt must reach NFFT+NCP-1, which is below 2*NFFT
    localparam int c_RW = c_AW + 1;
    localparam logic [c_RW-1:0] c_LAST_R = c_RW'(NFFT + NCP - 1);
    localparam logic [c_RW-1:0] c_OFS    = c_RW'(NFFT - NCP);
    localparam logic [c_AW-1:0] c_LAST_W = c_AW'(NFFT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [31:0]     r_mem [0:2*NFFT-1];
    logic [1:0]      r_full;
    logic [1:0]      w_full_nxt;
    logic            r_wb;
    logic            r_rb;
    logic            w_rb_nxt;
    logic [c_AW-1:0] r_wcnt;
    logic [c_RW-1:0] r_rcnt;
    logic [c_RW-1:0] w_rcnt_nxt;
    logic            r_drain;
    logic            r_cyc;
    logic            r_stb;
    logic            w_stb_nxt;
    logic            r_arm;
    logic [31:0]     r_dat;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_ack;
    logic            w_wlast;
    logic            w_xfer;
    logic            w_load;
    logic            w_release;
    logic [c_AW-1:0] w_rd_idx;
    logic [c_AW:0]   w_rd_addr;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign w_ack   = RST_I & CYC_I & STB_I & WE_I & ~r_full[r_wb] & ~r_drain;
    assign w_wlast = w_ack && (r_wcnt == c_LAST_W);

    always_ff @(posedge CLK_I) begin
        if (w_ack) begin
            r_mem[{r_wb, r_wcnt}] <= DAT_I;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    assign w_xfer = r_stb & ACK_I;

    always_comb begin
        w_state_nxt = r_state;
        w_stb_nxt   = r_stb;
        w_rcnt_nxt  = r_rcnt;
        w_rb_nxt    = r_rb;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_arm delays the start by one edge so a freshly filled bank
                // is seen a full cycle before the first word is launched
                if (r_arm && r_full[r_rb]) begin
                    w_state_nxt = S_SEND;
                    w_stb_nxt   = 1'b1;
                    w_rcnt_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_rcnt == c_LAST_R) begin
                        w_release  = 1'b1;
                        w_rb_nxt   = ~r_rb;
                        w_rcnt_nxt = '0;
                        if (r_full[~r_rb]) begin
                            w_load = 1'b1;       // next symbol follows with no bubble
                        end else begin
                            w_stb_nxt   = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                        w_load     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    // Word to launch next: (rcnt + NFFT-NCP) mod NFFT in the bank being read
    assign w_rd_idx  = c_AW'(w_rcnt_nxt + c_OFS);
    assign w_rd_addr = {w_rb_nxt, w_rd_idx};

    // A released bank and a newly filled bank are always different banks,
    // so both updates can land on the same edge
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_wlast) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= S_IDLE;
            r_stb   <= 1'b0;
            r_cyc   <= 1'b0;
            r_dat   <= '0;
            r_rcnt  <= '0;
            r_rb    <= 1'b0;
            r_wb    <= 1'b0;
            r_wcnt  <= '0;
            r_full  <= '0;
            r_drain <= 1'b0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stb   <= w_stb_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_rb    <= w_rb_nxt;
            r_full  <= w_full_nxt;
            r_arm   <= (r_state == S_IDLE) && r_full[r_rb] && !w_load;

            if (w_load) begin
                r_dat <= r_mem[w_rd_addr];
            end

            // An upstream cycle that ends mid-symbol discards the partial symbol
            if (w_ack) begin
                if (w_wlast) begin
                    r_wb   <= ~r_wb;
                    r_wcnt <= '0;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end else if (!CYC_I) begin
                r_wcnt <= '0;
            end

            // CYC_O opens with the first word of a frame and closes only
            // once the drain has emptied both banks
            if (r_drain && (r_full == 2'b00) && (r_state == S_IDLE)) begin
                r_drain <= 1'b0;
                r_cyc   <= 1'b0;
            end else begin
                if (!CYC_I && r_cyc) begin
                    r_drain <= 1'b1;
                end
                if (w_load && (r_state == S_IDLE)) begin
                    r_cyc <= 1'b1;
                end
            end
        end
    end

    assign ACK_O = w_ack;
    assign DAT_O = r_dat;
    assign CYC_O = r_cyc;
    assign STB_O = r_stb;
    assign WE_O  = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_cp_insert.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp_insert
//  Description : Directed self-checking bench for cp_insert (NFFT=64, NCP=16)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cp_insert;

    logic        CLK_I;
    logic        RST_I;
    logic [31:0] DAT_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;

    cp_insert #(.NFFT(64), .NCP(16)) u_dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .DAT_I (DAT_I),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ACK_O (ACK_O),
        .DAT_O (DAT_O),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ACK_I (ACK_I)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    logic [31:0] got_q[$];
    int          got_cyc_q[$];
    bit          stb_seen     = 1'b0;
    int          first_stb_cyc = 0;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_val     = '0;
    int          hold_cnt     = 0;
    int          drops        = 0;
    logic        prev_cyc_o   = 1'b0;

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_dat", DAT_O, hold_val);
                check("hold_stb", {31'd0, STB_O}, 32'd1);
                hold_cnt++;
            end
            hold_pending = STB_O && !ACK_I;
            hold_val     = DAT_O;
            if (STB_O && !stb_seen) begin
                stb_seen      = 1'b1;
                first_stb_cyc = cyc;
                check("we_o", {31'd0, WE_O}, 32'd1);
            end
            if (STB_O && ACK_I) begin
                got_q.push_back(DAT_O);
                got_cyc_q.push_back(cyc);
            end
            if (prev_cyc_o && !CYC_O) drops++;
        end
        prev_cyc_o = CYC_O;
    end

    task automatic clear_mon();
        got_q.delete();
        got_cyc_q.delete();
        stb_seen = 1'b0;
    endtask

    task automatic do_reset();
        RST_I = 1'b0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        ACK_I = 1'b0; DAT_I = 32'hFFFF_FFFF;
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_dat", DAT_O, 32'd0);
        check("rst_stb", {31'd0, STB_O}, 32'd0);
        check("rst_cyc", {31'd0, CYC_O}, 32'd0);
        check("rst_ack", {31'd0, ACK_O}, 32'd0);
        check("rst_we",  {31'd0, WE_O},  32'd0);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
    endtask

    // Offer samples base+k; returns the edge number of the last accept and
    // the number of cycles spent
    task automatic write_words(input int n, input int base, output int acc_cyc, output int iters);
        int k = 0;
        int g = 0;
        acc_cyc = 0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        while (k < n && g < 3000) begin
            DAT_I = base + k;
            @(negedge CLK_I);
            if (ACK_O) begin
                acc_cyc = cyc + 1;
                k++;
            end
            @(posedge CLK_I); #1;
            g++;
        end
        STB_I = 1'b0; WE_I = 1'b0;
        iters = g;
        check("write_count", k, n);
    endtask

    task automatic wait_words(input int n, input int bound);
        int t = 0;
        while (got_q.size() < n && t < bound) begin
            @(posedge CLK_I); #1;
            t++;
        end
        check("word_count", got_q.size(), n);
    endtask

    task automatic wait_cyc_low(input int bound);
        int t = 0;
        while (CYC_O && t < bound) begin
            @(posedge CLK_I); #1;
            t++;
        end
        check("cyc_low", {31'd0, CYC_O}, 32'd0);
    endtask

    task automatic check_symbol(input string tag, input int base);
        for (int i = 0; i < 80 && i < got_q.size(); i++) begin
            check(tag, got_q[i], base + ((i + 48) % 64));
        end
    endtask

    task automatic run_single(input int base);
        int acc_cyc;
        int iters;
        clear_mon();
        ACK_I = 1'b1;
        write_words(64, base, acc_cyc, iters);
        CYC_I = 1'b0;
        wait_words(80, 300);
        check("latency", first_stb_cyc, acc_cyc + 2);
        check_symbol("single_word", base);
        check("cyc_after_last", {31'd0, CYC_O}, 32'd1);
        check("stb_after_last", {31'd0, STB_O}, 32'd0);
        @(posedge CLK_I); #1;
        check("cyc_release", {31'd0, CYC_O}, 32'd0);
    endtask

    initial begin
        int acc_cyc;
        int iters;
        int d0;
        int h0;
        int s10;
        int s70;
        int acc;
        int n_at_ack;
        int bad;
        int t;

        RST_I = 1'b0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b0; DAT_I = '0;
        do_reset();

        // Single symbol
        run_single(0);

        // Three symbols back to back
        clear_mon();
        d0 = drops;
        ACK_I = 1'b1;
        write_words(192, 0, acc_cyc, iters);
        check("b2b_throttle", iters - 192, 18);
        wait_words(240, 400);
        for (int i = 0; i < 240 && i < got_q.size(); i++) begin
            check("b2b_word", got_q[i], (i / 80) * 64 + ((i % 80) + 48) % 64);
        end
        if (got_cyc_q.size() == 240) check("b2b_no_gap", got_cyc_q[239] - got_cyc_q[0], 239);
        else check("b2b_no_gap", got_cyc_q.size(), 240);
        CYC_I = 1'b0;
        wait_cyc_low(20);
        check("b2b_cyc_continuous", drops - d0, 1);

        // Downstream stalls at word 10 and word 70
        clear_mon();
        h0 = hold_cnt;
        ACK_I = 1'b1;
        write_words(64, 400, acc_cyc, iters);
        s10 = 0; s70 = 0;
        for (int i = 0; i < 400 && got_q.size() < 80; i++) begin
            if (got_q.size() == 10 && s10 < 5) begin
                ACK_I = 1'b0; s10++;
            end else if (got_q.size() == 70 && s70 < 3) begin
                ACK_I = 1'b0; s70++;
            end else begin
                ACK_I = 1'b1;
            end
            @(posedge CLK_I); #1;
        end
        ACK_I = 1'b1;
        check("stall_count", got_q.size(), 80);
        check_symbol("stall_word", 400);
        check("stall_holds", hold_cnt - h0, 8);
        CYC_I = 1'b0;
        wait_cyc_low(20);

        // Partial symbol is dropped, then a drain blocks a new frame
        clear_mon();
        ACK_I = 1'b1;
        write_words(30, 500, acc_cyc, iters);
        CYC_I = 1'b0;
        repeat (20) @(posedge CLK_I);
        #1;
        check("part_no_stb", {31'd0, stb_seen}, 32'd0);
        check("part_cyc", {31'd0, CYC_O}, 32'd0);
        write_words(64, 600, acc_cyc, iters);
        CYC_I = 1'b0;
        t = 0;
        while (!CYC_O && t < 10) begin
            @(posedge CLK_I); #1; t++;
        end
        check("drain_cyc_up", {31'd0, CYC_O}, 32'd1);
        repeat (3) @(posedge CLK_I);
        #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 32'hDEAD_0000;
        bad = 0; t = 0;
        while (CYC_O && t < 200) begin
            if (ACK_O) bad++;
            @(posedge CLK_I); #1; t++;
        end
        check("drain_ack_blocked", bad, 0);
        check("drain_cyc_fell", {31'd0, CYC_O}, 32'd0);
        check("post_drain_ack", {31'd0, ACK_O}, 32'd1);
        STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
        check("drain_words", got_q.size(), 80);
        check_symbol("drain_word", 600);

        // Both banks full with the downstream stalled
        clear_mon();
        ACK_I = 1'b0;
        acc = 0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        for (int i = 0; i < 150 && acc < 130; i++) begin
            DAT_I = acc;
            @(negedge CLK_I);
            if (ACK_O) acc++;
            @(posedge CLK_I); #1;
        end
        check("full_accepted", acc, 128);
        check("full_ack_low", {31'd0, ACK_O}, 32'd0);
        ACK_I = 1'b1;
        n_at_ack = -1;
        for (int i = 0; i < 200; i++) begin
            if (ACK_O) begin
                n_at_ack = got_q.size();
                break;
            end
            @(posedge CLK_I); #1;
        end
        STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
        check("full_release_after", n_at_ack, 80);
        if (got_q.size() > 0) check("full_first_word", got_q[0], 32'd48);
        else check("full_first_word", got_q.size(), 1);

        // Reset in the middle of a symbol
        do_reset();
        clear_mon();
        ACK_I = 1'b1;
        write_words(64, 700, acc_cyc, iters);
        CYC_I = 1'b0;
        t = 0;
        while (got_q.size() < 40 && t < 200) begin
            @(posedge CLK_I); #1; t++;
        end
        check("mid_stb_before", {31'd0, STB_O}, 32'd1);
        check("mid_dat_before", DAT_O, 32'd700 + 32'd24);
        #2;
        RST_I = 1'b0;
        #1;
        check("mid_rst_stb", {31'd0, STB_O}, 32'd0);
        check("mid_rst_cyc", {31'd0, CYC_O}, 32'd0);
        check("mid_rst_dat", DAT_O, 32'd0);
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        run_single(800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
